load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Executes one RV32I load or store per request, handling the handshake with a simple data-memory port that may insert wait states.
- Aligns and sign/zero-extends load data.
- Drives the register file write port (wrtEn/wrtReg/wrtData) directly, sitting between execute and the register file.
- Holds busy high while in progress so the core stalls the PC.

Parameters:
TIMEOUT_CYCLES, 255, REQ cycles without mem_ready before the access is aborted with err
TO_W, 8, width of timeout counter; must satisfy 2**TO_W > TIMEOUT_CYCLES

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse from decode/execute
is_store  input  1  1 = store, 0 = load
funct3  input  3  RV32I width/sign encoding
addr  input  32  effective byte address (rs1 + imm)
store_data  input  32  rs2 value
rd  input  5  load destination register
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse on successful completion
err  output  1  one-cycle pulse on misalign, illegal funct3 or timeout
mem_req  output  1  memory request valid
mem_we  output  1  write enable
mem_addr  output  32  word address: {addr[31:2], 2'b00}
mem_wdata  output  32  lane-replicated store data
mem_wstrb  output  4  byte enables, zero for loads
mem_ready  input  1  memory accepts or completes the request this cycle
mem_rdata  input  32  read word, valid when mem_ready=1
wrtEn  output  1  register file write enable
wrtReg  output  5  register file write address
wrtData  output  32  register file write data

Behaviour:
- Reset: async on rst high. State goes to IDLE; timeout counter cleared; every output is 0, including mem_req, which drops immediately.
- States are IDLE, REQ, DONE and FAIL.
- IDLE:
  - start is sampled only in IDLE; start while busy is ignored.
  - On start, latch is_store, funct3, addr, store_data and rd.
  - If the request is legal, go to REQ; otherwise go to FAIL.
- Legal loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- Legal stores: SB=000, SH=001, SW=010.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0. Misaligned requests go to FAIL.
- REQ:
  - mem_req=1 with mem_addr, mem_we, mem_wdata and mem_wstrb stable until mem_ready is sampled high.
  - mem_ready may already be high in the first REQ cycle.
  - On mem_ready, a load captures the extracted and extended data and goes to DONE; a store goes to DONE.
  - The counter increments each REQ cycle without mem_ready. On reaching TIMEOUT_CYCLES, mem_req drops and the state goes to FAIL.
- DONE (1 cycle):
  - done=1.
  - For a load, wrtEn=1, wrtReg=rd, wrtData=aligned value. wrtEn is suppressed when rd=0.
  - Next state is IDLE.
- FAIL (1 cycle): err=1, no memory access, wrtEn=0; next state is IDLE.
- Latency with a zero-wait memory: start at cycle T, mem_req at T+1, done/wrtEn at T+2. Each wait state adds one cycle. A new start is accepted at T+3.
- Store lanes:
  - SB: mem_wstrb = 0001 << addr[1:0]; mem_wdata = {4{store_data[7:0]}}.
  - SH: mem_wstrb = addr[1] ? 1100 : 0011; mem_wdata = {2{store_data[15:0]}}.
  - SW: mem_wstrb = 1111; mem_wdata = store_data.
- Load extract: byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16]. LB/LH sign-extend; LBU/LHU zero-extend.
- Outputs outside their active state are 0: wrtEn/wrtReg/wrtData outside DONE, mem_* outside REQ.
- Reset asserted mid-REQ or mid-DONE aborts the access with no write and no done/err pulse.

Decomposition:
- Shared rv32_defs package/include: funct3 localparams (F3_LB … F3_SW) and the state encodings IDLE/REQ/DONE/FAIL (2-bit).
- One combinational sub-module, load_align: inputs funct3, addr[1:0], mem_rdata; output 32-bit extended result. It is reused by verification as the reference model.

Test Plan:
- LBU addr 0x00001003, mem_rdata 0xAABBCCDD, zero wait, rd=5 -> DONE at T+2, wrtEn=1, wrtReg=5, wrtData=0x000000AA. Repeat as LB -> 0xFFFFFFAA; LH at 0x1002 -> 0xFFFFAABB.
- SH addr 0x00002002, store_data 0x1234ABCD -> mem_we=1, mem_addr=0x00002000, mem_wstrb=1100, mem_wdata=0xABCDABCD, done at T+2, wrtEn never high.
- LW addr 0x00001001 -> err pulse at T+1, mem_req never asserted, wrtEn=0, busy low at T+2. Same result for funct3=011 load.
- LW 0x100 with mem_ready withheld 3 cycles, start re-pulsed during REQ -> mem_req held 4 cycles with stable addr, second start ignored, exactly one write, done at T+5.
- TIMEOUT_CYCLES=4, mem_ready never asserted -> mem_req high 4 cycles then low, err pulse, no write. LW with rd=0 -> done=1, wrtEn=0.
- rst raised mid-REQ -> mem_req, busy and all outputs 0 in the same cycle (async), no done/err. After rst release, a fresh LW completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit_pkg                                          |
// | Description : Shared RV32I load/store definitions: funct3 encodings, LSU   |
// |               state encoding and the request legality check.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package load_store_unit_pkg;

    // Load encodings. Store encodings share the same values for byte/half/word.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } lsu_state_t;

    // A request is legal when funct3 names an access of the right kind and the
    // address is naturally aligned for its width.
    function automatic logic req_legal(input logic       st,
                                       input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB:   ok = 1'b1;                    // LB / SB
            F3_LH:   ok = ~addr_lo[0];             // LH / SH
            F3_LW:   ok = (addr_lo == 2'b00);      // LW / SW
            F3_LBU:  ok = ~st;
            F3_LHU:  ok = ~st & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : load_store_unit_pkg
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_align                                                   |
// | Description : Combinational load-data extractor. Selects the addressed     |
// |               byte/halfword of the memory word and sign/zero-extends it.   |
// | Ports       : funct3  - load width/sign encoding                           |
// |               addr_lo - byte offset within the word                        |
// |               mem_rdata - full memory read word                            |
// |               result  - extended 32-bit value for the register file        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_rdata,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = mem_rdata[{addr_lo, 3'b000} +: 8];
        sel_half = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   result = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   result = {{16{sel_half[15]}}, sel_half};
            F3_LW:   result = mem_rdata;
            F3_LBU:  result = {24'd0, sel_byte};
            F3_LHU:  result = {16'd0, sel_half};
            default: result = 32'd0;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit                                              |
// | Description : Executes one RV32I load or store per start pulse against a   |
// |               data-memory port with wait states, then writes load results  |
// |               straight into the register file.                             |
// | Ports       : start/is_store/funct3/addr/store_data/rd - request           |
// |               busy/done/err - status (done/err are 1-cycle pulses)         |
// |               mem_*  - memory request/response port                        |
// |               wrtEn/wrtReg/wrtData - register file write port              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wrtEn,
    output logic [4:0]  wrtReg,
    output logic [31:0] wrtData
);

    // Last REQ cycle index before abort: the counter starts at 0 in the first
    // REQ cycle, so TIMEOUT_CYCLES cycles without ready end at this value.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t     state;
    logic [TO_W-1:0] to_cnt;
    logic           is_store_q;
    logic [2:0]     funct3_q;
    logic [1:0]     addr_lo_q;
    logic [4:0]     rd_q;

    logic [3:0]     st_wstrb;
    logic [31:0]    st_wdata;
    logic [31:0]    load_value;

    // Store lane replication computed from the live request so it can be
    // registered straight into the memory outputs on acceptance.
    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = 32'd0;
        case (funct3)
            F3_SB: begin
                st_wstrb = 4'b0001 << addr[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            F3_SH: begin
                st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            F3_SW: begin
                st_wstrb = 4'b1111;
                st_wdata = store_data;
            end
            default: begin
                st_wstrb = 4'b0000;
                st_wdata = 32'd0;
            end
        endcase
    end

    load_align u_load_align (
        .funct3    (funct3_q),
        .addr_lo   (addr_lo_q),
        .mem_rdata (mem_rdata),
        .result    (load_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            to_cnt     <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_lo_q  <= 2'd0;
            rd_q       <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_wstrb  <= 4'd0;
            wrtEn      <= 1'b0;
            wrtReg     <= 5'd0;
            wrtData    <= 32'd0;
        end else begin
            // Pulse outputs default low; they are only raised on entry to
            // DONE/FAIL, which last exactly one cycle.
            done    <= 1'b0;
            err     <= 1'b0;
            wrtEn   <= 1'b0;
            wrtReg  <= 5'd0;
            wrtData <= 32'd0;

            case (state)
                IDLE: begin
                    if (start) begin
                        is_store_q <= is_store;
                        funct3_q   <= funct3;
                        addr_lo_q  <= addr[1:0];
                        rd_q       <= rd;
                        to_cnt     <= '0;
                        busy       <= 1'b1;
                        if (req_legal(is_store, funct3, addr[1:0])) begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= is_store ? st_wdata : 32'd0;
                            mem_wstrb <= is_store ? st_wstrb : 4'b0000;
                        end else begin
                            state <= FAIL;
                            err   <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    if (mem_ready || (to_cnt == TO_LAST)) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_wdata <= 32'd0;
                        mem_wstrb <= 4'd0;
                    end
                    if (mem_ready) begin
                        state <= DONE;
                        done  <= 1'b1;
                        if (!is_store_q) begin
                            wrtEn   <= (rd_q != 5'd0);
                            wrtReg  <= rd_q;
                            wrtData <= load_value;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state <= FAIL;
                        err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                DONE, FAIL: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    to_cnt <= '0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : load_store_unit
`default_nettype wire
